// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory request arbiter
package mem_pkg;
  typedef enum logic [1:0] {IDLE, XFER, WAIT_ACK} state_t;
  localparam int SRC_ID_W = 2;
  localparam int BYTE_W = 8;
  localparam int ACK_TIMEOUT_DEF = 4096;
endpackage

// File: rtl/mem_rr_pick.sv
// mem_rr_pick: 4-way round-robin selector starting after last_grant
module mem_rr_pick
  import mem_pkg::*;
(
  input  logic [3:0]          req,
  input  logic [SRC_ID_W-1:0] last_grant,
  output logic [SRC_ID_W-1:0] winner,
  output logic                any
);
  always_comb begin
    winner = last_grant;
    for (int k = 3; k >= 0; k--)
      if (req[last_grant + SRC_ID_W'(k + 1)]) winner = last_grant + SRC_ID_W'(k + 1);
  end
  assign any = |req;
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin byte-stream arbiter with per-source ack routing and timeout
module mem_req_arbiter
  import mem_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int N_REQ = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [BYTE_W*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      mem_valid,
  output logic [BYTE_W-1:0]         mem_data,
  input  logic                      mem_ready,
  input  logic                      mem_ack_valid,
  input  logic [SRC_ID_W-1:0]       mem_ack_id,
  output logic                      mem_ack_ready,
  output logic [N_REQ-1:0]          ack_valid,
  input  logic [N_REQ-1:0]          ack_ready,
  output logic [SRC_ID_W-1:0]       grant_id,
  output logic                      busy,
  output logic                      err
);
  state_t state, state_nx;
  logic [SRC_ID_W-1:0] grant_q, last_grant, pick;
  logic [15:0] timer;
  logic err_q, any, live, xfer, wait_st, beat, ack_hs, ack_match, expire;

  mem_rr_pick u_pick (.req(req_valid), .last_grant(last_grant), .winner(pick), .any(any));

  // every output path is forced quiet while reset is held
  assign live = !rst;
  assign xfer = live && state == XFER;
  assign wait_st = live && state == WAIT_ACK;
  assign mem_valid = xfer & req_valid[grant_q];
  assign mem_data = xfer ? req_data[{grant_q, 3'b000} +: BYTE_W] : '0;
  assign req_ready = xfer ? N_REQ'(mem_ready) << grant_q : '0;
  assign ack_valid = live ? N_REQ'(mem_ack_valid) << mem_ack_id : '0;
  assign mem_ack_ready = live & ack_ready[mem_ack_id];
  assign grant_id = live ? grant_q : '0;
  assign err = live & err_q;
  assign busy = live && state != IDLE;
  assign beat = mem_valid & mem_ready;
  assign ack_hs = mem_ack_valid & mem_ack_ready;
  assign ack_match = wait_st && ack_hs && mem_ack_id == grant_q;
  // timer reads k on the k-th cycle after entry, so expiry lands ACK_TIMEOUT cycles in
  assign expire = wait_st && timer == 16'(ACK_TIMEOUT - 1);

  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (any ? XFER : IDLE) :
               state == XFER ? (beat && req_last[grant_q] ? WAIT_ACK : XFER) :
               (ack_match || expire ? IDLE : WAIT_ACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 2'd3;
      grant_q <= '0;
      timer <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any) grant_q <= pick;
      timer <= state == WAIT_ACK ? timer + 16'd1 : '0;
      if (ack_match || expire) last_grant <= grant_q;
      if ((ack_hs || expire) && !ack_match) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req_valid = '0, req_last = '0, req_ready, ack_valid, ack_ready = '0;
  logic [31:0] req_data = '0;
  logic mem_valid, mem_ready = 1'b0, mem_ack_valid = 1'b0, mem_ack_ready, busy, err;
  logic [7:0] mem_data;
  logic [1:0] mem_ack_id = '0, grant_id;
  int n_tests = 0, n_fail = 0;
  logic [7:0] got[$];

  mem_req_arbiter #(.ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .mem_valid(mem_valid), .mem_data(mem_data), .mem_ready(mem_ready),
    .mem_ack_valid(mem_ack_valid), .mem_ack_id(mem_ack_id), .mem_ack_ready(mem_ack_ready),
    .ack_valid(ack_valid), .ack_ready(ack_ready), .grant_id(grant_id), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_valid && mem_ready) got.push_back(mem_data);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ack(input logic [1:0] id);
    mem_ack_valid = 1'b1;
    mem_ack_id = id;
    ack_ready = 4'b0001 << id;
  endtask

  task automatic ack_clr();
    mem_ack_valid = 1'b0;
    ack_ready = '0;
  endtask

  initial begin
    tick();
    tick();
    req_valid = 4'hF; mem_ready = 1'b1; mem_ack_valid = 1'b1; ack_ready = 4'hF;
    #1;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_ack_valid", ack_valid, 0);
    chk("rst_mem_ack_ready", mem_ack_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_err", err, 0);
    tick();
    req_valid = '0; mem_ready = 1'b0; ack_clr(); rst = 1'b0;
    // round robin: req0 and req2 together
    req_valid = 4'b0101; req_last = 4'b0101; req_data = 32'h00C2_00A0; mem_ready = 1'b1;
    tick();
    chk("rr_grant0", grant_id, 0);
    chk("rr_data0", mem_data, 8'hA0);
    chk("rr_ready0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0100;
    #1;
    chk("rr_wait0", {busy, mem_valid}, 2'b10);
    ack(0);
    #1;
    chk("rr_ackv0", ack_valid, 4'b0001);
    chk("rr_ackr0", mem_ack_ready, 1);
    tick();
    ack_clr();
    chk("rr_idle0", busy, 0);
    tick();
    chk("rr_grant2", grant_id, 2);
    chk("rr_data2", mem_data, 8'hC2);
    req_valid = 4'b0101;
    tick();
    ack(2);
    tick();
    ack_clr();
    tick();
    chk("rr_grant0_again", grant_id, 0);
    tick();
    req_valid = '0;
    ack(0);
    tick();
    ack_clr();
    chk("rr_done", {busy, err}, 2'b00);
    // req1 three beats with mem_ready toggling
    got.delete();
    req_valid = 4'b0010; req_last = '0; req_data = 32'h0000_9F00; mem_ready = 1'b1;
    tick();
    chk("x_grant1", grant_id, 1);
    chk("x_b0", {mem_valid, mem_data, req_ready}, {1'b1, 8'h9F, 4'b0010});
    tick();
    req_data = 32'h0000_0000; mem_ready = 1'b0;
    #1;
    chk("x_stall", {mem_valid, req_ready}, {1'b1, 4'b0000});
    tick();
    mem_ready = 1'b1;
    #1;
    chk("x_b1", req_ready, 4'b0010);
    tick();
    req_data = 32'h0000_1000; req_last = 4'b0010; mem_ready = 1'b0;
    tick();
    mem_ready = 1'b1;
    #1;
    chk("x_b2", {mem_data, req_ready}, {8'h10, 4'b0010});
    tick();
    chk("x_wait", {busy, mem_valid, req_ready}, {1'b1, 1'b0, 4'b0000});
    chk("x_nbeats", got.size(), 3);
    if (got.size() == 3) chk("x_order", {got[0], got[1], got[2]}, 24'h9F_00_10);
    // mismatched ack id while granted to 1
    req_valid = '0;
    ack(2);
    #1;
    chk("mm_ackv", ack_valid, 4'b0100);
    tick();
    ack_clr();
    chk("mm_err_busy", {err, busy}, 2'b11);
    ack(1);
    tick();
    ack_clr();
    chk("mm_sticky", {err, busy}, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mm_rst_clr", err, 0);
    // requester 3 with ack backpressure
    req_valid = 4'b1000; req_last = 4'b1000; req_data = 32'h3300_0000;
    tick();
    chk("bp_grant3", grant_id, 3);
    tick();
    req_valid = '0;
    mem_ack_valid = 1'b1; mem_ack_id = 2'd3; ack_ready = '0;
    #1;
    chk("bp_ackv", {ack_valid, mem_ack_ready}, {4'b1000, 1'b0});
    tick();
    chk("bp_hold1", {ack_valid, busy}, {4'b1000, 1'b1});
    tick();
    chk("bp_hold2", {ack_valid, busy}, {4'b1000, 1'b1});
    ack_ready = 4'b1000;
    tick();
    ack_clr();
    chk("bp_idle", {busy, err}, 2'b00);
    // timeout: ACK_TIMEOUT = 8
    req_valid = 4'b0001; req_last = 4'b0001;
    tick();
    tick();
    req_valid = '0;
    for (int i = 1; i <= 7; i++) tick();
    chk("to_still_wait", {busy, err}, 2'b10);
    tick();
    chk("to_idle_err", {busy, err}, 2'b01);
    tick();
    tick();
    chk("to_err_sticky", err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    // reset mid-transfer after one of three beats
    req_valid = 4'b0010; req_last = '0; req_data = 32'h0000_5500;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mr_in_rst", {mem_valid, req_ready, busy}, 6'b0);
    tick();
    rst = 1'b0;
    req_valid = 4'b0110;
    #1;
    chk("mr_idle", {busy, mem_valid, req_ready}, 6'b0);
    tick();
    chk("mr_last3", grant_id, 1);
    // matching ack on the expiry cycle wins
    req_valid = 4'b0010; req_last = 4'b0010;
    tick();
    req_valid = '0;
    for (int i = 1; i <= 7; i++) tick();
    ack(1);
    tick();
    ack_clr();
    chk("race_ack_wins", {busy, err}, 2'b00);
    // ack handshake while idle
    ack(0);
    tick();
    ack_clr();
    chk("idle_ack_err", {busy, err}, 2'b01);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
